// File: rtl/manycore_mesh_router.sv
// Five-port XY mesh router: 2-entry FIFO per input, round-robin arbiter per output.
// Optional MANYCORE_MESH_ROUTER_BOUNDS_DROP_EN drops packets addressed outside the mesh.
module manycore_mesh_router #(
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned packet_width_p = 64,
  parameter int unsigned x_max_p        = 16,
  parameter int unsigned y_max_p        = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [4:0]                     v_i,
  input  logic [4:0][packet_width_p-1:0] data_i,
  output logic [4:0]                     ready_o,
  output logic [4:0]                     v_o,
  output logic [4:0][packet_width_p-1:0] data_o,
  input  logic [4:0]                     ready_i,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i
);

  if (packet_width_p < x_cord_width_p + y_cord_width_p || x_max_p == 0 || y_max_p == 0)
  begin : g_param_check
    $error("manycore_mesh_router: illegal parameter combination");
  end

  typedef logic [packet_width_p-1:0] pkt_t;

  // Entry 0 of each FIFO is always the head.
  pkt_t [4:0][1:0] mem_q, mem_d;
  logic [4:0][1:0] cnt_q, cnt_d;
  logic [4:0][2:0] last_q, last_d;

  logic [4:0][x_cord_width_p-1:0] dest_x;
  logic [4:0][y_cord_width_p-1:0] dest_y;
  logic [4:0][4:0]                req;    // req[input][output]
  logic [4:0]                     drop;
  logic [4:0]                     deq;
  logic [4:0]                     enq;
  logic [4:0][2:0]                grant;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      ready_o[i] = (cnt_q[i] != 2'd2);
    end
    enq = v_i & ready_o;
  end

  always_comb begin
    logic oob;
    req  = '0;
    drop = '0;
    oob  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dest_x[i] = mem_q[i][0][x_cord_width_p-1:0];
      dest_y[i] = mem_q[i][0][x_cord_width_p+y_cord_width_p-1:x_cord_width_p];
`ifdef MANYCORE_MESH_ROUTER_BOUNDS_DROP_EN
      oob = (32'(dest_x[i]) >= x_max_p) || (32'(dest_y[i]) >= y_max_p);
`else
      oob = 1'b0;
`endif
      if (cnt_q[i] != 2'd0) begin
        if (oob)                       drop[i]   = 1'b1;
        else if (dest_x[i] < my_x_i)   req[i][1] = 1'b1;
        else if (dest_x[i] > my_x_i)   req[i][2] = 1'b1;
        else if (dest_y[i] < my_y_i)   req[i][3] = 1'b1;
        else if (dest_y[i] > my_y_i)   req[i][4] = 1'b1;
        else                           req[i][0] = 1'b1;
      end
    end
  end

  // Grant ignores ready_i so a stalled output keeps presenting the same head.
  always_comb begin
    int idx;
    v_o    = '0;
    data_o = '0;
    grant  = '0;
    idx    = 0;
    for (int j = 0; j < 5; j++) begin
      for (int off = 1; off <= 5; off++) begin
        idx = int'(last_q[j]) + off;
        if (idx >= 5) idx = idx - 5;
        if (!v_o[j] && req[idx][j]) begin
          v_o[j]   = 1'b1;
          grant[j] = 3'(idx);
        end
      end
      if (v_o[j]) data_o[j] = mem_q[grant[j]][0];
    end
  end

  always_comb begin
    deq    = drop;
    last_d = last_q;
    for (int j = 0; j < 5; j++) begin
      if (v_o[j] && ready_i[j]) begin
        deq[grant[j]] = 1'b1;
        last_d[j]     = grant[j];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (deq[i]) begin
        mem_d[i][0] = mem_q[i][1];
        cnt_d[i]    = cnt_q[i] - 2'd1;
      end
      // enq only when not full, so the post-dequeue count is 0 or 1.
      if (enq[i]) begin
        mem_d[i][cnt_d[i][0]] = data_i[i];
        cnt_d[i]              = cnt_d[i] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q  <= '0;
      cnt_q  <= '0;
      last_q <= {5{3'd4}};
    end else begin
      mem_q  <= mem_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_manycore_mesh_router.sv
// Self-checking bench for manycore_mesh_router: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours MANYCORE_MESH_ROUTER_BOUNDS_DROP_EN.
module tb_manycore_mesh_router;

  localparam int PW = 64;
  localparam int P = 0, W = 1, E = 2, N = 3, S = 4;
`ifdef MANYCORE_MESH_ROUTER_BOUNDS_DROP_EN
  localparam int XMAX = 4;
`else
  localparam int XMAX = 16;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [4:0]         v_i = '0;
  logic [4:0][PW-1:0] data_i = '0;
  logic [4:0]         ready_o;
  logic [4:0]         v_o;
  logic [4:0][PW-1:0] data_o;
  logic [4:0]         ready_i = '1;
  logic [3:0]         my_x = 4'd2;
  logic [3:0]         my_y = 4'd3;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [PW-1:0] mq[5][$];
  int            mlast[5];

  manycore_mesh_router #(
    .x_cord_width_p(4),
    .y_cord_width_p(4),
    .packet_width_p(PW),
    .x_max_p       (XMAX),
    .y_max_p       (16)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .ready_i  (ready_i),
    .my_x_i   (my_x),
    .my_y_i   (my_y)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk_pkt(int x, int y);
    logic [PW-1:0] p;
    p      = {$urandom(), $urandom()};
    p[3:0] = 4'(x);
    p[7:4] = 4'(y);
    return p;
  endfunction

  function automatic int model_route(logic [PW-1:0] p);
    int dx, dy, mx, my;
    dx = int'(p[3:0]);
    dy = int'(p[7:4]);
    mx = int'(my_x);
    my = int'(my_y);
    if (dx < mx) return W;
    if (dx > mx) return E;
    if (dy < my) return N;
    if (dy > my) return S;
    return P;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    v_i     = '0;
    ready_i = '1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (v_o !== 5'b0) $display("FAIL reset_v: got %b want %b", v_o, 5'b0);
    else n_pass++;
    n_checks++;
    if (ready_o !== 5'b11111) $display("FAIL reset_ready: got %b want %b", ready_o, 5'b11111);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_checks++;
    if (v_o !== 5'b0 || ready_o !== 5'b11111)
      $display("FAIL reset_release: got v=%b rdy=%b want v=0 rdy=11111", v_o, ready_o);
    else n_pass++;
  endtask

  task automatic test_local();
    logic [PW-1:0] p;
    my_x = 4'd2; my_y = 4'd3;
    do_reset();
    p = mk_pkt(2, 3);
    v_i[W] = 1'b1; data_i[W] = p;
    step();
    v_i = '0;
    n_checks++;
    if (v_o !== 5'b00001) $display("FAIL local_v: got %b want %b", v_o, 5'b00001);
    else n_pass++;
    n_checks++;
    if (data_o[P] !== p) $display("FAIL local_data: got %h want %h", data_o[P], p);
    else n_pass++;
    step();
    n_checks++;
    if (v_o !== 5'b0) $display("FAIL local_drain: got %b want %b", v_o, 5'b0);
    else n_pass++;
  endtask

  task automatic test_directions();
    int xs[4] = '{0, 3, 2, 2};
    int ys[4] = '{3, 3, 1, 7};
    int ds[4] = '{W, E, N, S};
    logic [PW-1:0] p;
    logic [4:0] want;
    my_x = 4'd2; my_y = 4'd3;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      p = mk_pkt(xs[k], ys[k]);
      v_i[P] = 1'b1; data_i[P] = p;
      step();
      want = 5'b1 << ds[k];
      n_checks++;
      if (v_o !== want || data_o[ds[k]] !== p)
        $display("FAIL dir_%0d: got v=%b d=%h want v=%b d=%h", k, v_o, data_o[ds[k]], want, p);
      else n_pass++;
    end
    v_i = '0;
    step();
    n_checks++;
    if (v_o !== 5'b0) $display("FAIL dir_drain: got %b want %b", v_o, 5'b0);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [PW-1:0] pk[5][2];
    int order[3] = '{P, W, N};
    int src;
    my_x = 4'd2; my_y = 4'd3;
    do_reset();
    ready_i[E] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++) begin
        pk[order[k]][s]     = mk_pkt(3, 3);
        v_i[order[k]]       = 1'b1;
        data_i[order[k]]    = pk[order[k]][s];
      end
      step();
    end
    v_i = '0;
    ready_i[E] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      src = order[k % 3];
      n_checks++;
      if (v_o[E] !== 1'b1 || data_o[E] !== pk[src][k / 3])
        $display("FAIL contend_%0d: got v=%b d=%h want v=1 d=%h", k, v_o[E], data_o[E],
                 pk[src][k / 3]);
      else n_pass++;
      step();
    end
    n_checks++;
    if (v_o !== 5'b0) $display("FAIL contend_drain: got %b want %b", v_o, 5'b0);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic [PW-1:0] p[3];
    my_x = 4'd2; my_y = 4'd3;
    do_reset();
    ready_i[E] = 1'b0;
    for (int k = 0; k < 3; k++) p[k] = mk_pkt(3, 3);
    v_i[W] = 1'b1; data_i[W] = p[0];
    step();
    n_checks++;
    if (ready_o[W] !== 1'b1) $display("FAIL bp_ready1: got %b want 1", ready_o[W]);
    else n_pass++;
    data_i[W] = p[1];
    step();
    data_i[W] = p[2];
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (ready_o[W] !== 1'b0 || v_o[E] !== 1'b1 || data_o[E] !== p[0])
        $display("FAIL bp_stall_%0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", c, ready_o[W],
                 v_o[E], data_o[E], p[0]);
      else n_pass++;
      step();
    end
    ready_i[E] = 1'b1;
    step();
    n_checks++;
    if (data_o[E] !== p[1] || ready_o[W] !== 1'b1)
      $display("FAIL bp_drain1: got rdy=%b d=%h want rdy=1 d=%h", ready_o[W], data_o[E], p[1]);
    else n_pass++;
    step();
    v_i = '0;
    n_checks++;
    if (v_o[E] !== 1'b1 || data_o[E] !== p[2])
      $display("FAIL bp_drain2: got v=%b d=%h want v=1 d=%h", v_o[E], data_o[E], p[2]);
    else n_pass++;
    step();
    n_checks++;
    if (v_o !== 5'b0) $display("FAIL bp_empty: got %b want %b", v_o, 5'b0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    my_x = 4'd2; my_y = 4'd3;
    do_reset();
    ready_i = '0;
    for (int s = 0; s < 2; s++) begin
      v_i = '1;
      for (int k = 0; k < 5; k++) data_i[k] = mk_pkt(2, 3);
      step();
    end
    v_i = '0;
    n_checks++;
    if (ready_o !== 5'b0 || v_o !== 5'b00001)
      $display("FAIL rmid_full: got rdy=%b v=%b want rdy=00000 v=00001", ready_o, v_o);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (v_o !== 5'b0 || ready_o !== 5'b11111)
      $display("FAIL rmid_async: got v=%b rdy=%b want v=0 rdy=11111", v_o, ready_o);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    ready_i = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (v_o !== 5'b0) $display("FAIL rmid_stale_%0d: got %b want %b", c, v_o, 5'b0);
      else n_pass++;
    end
  endtask

  task automatic test_bounds();
    logic [PW-1:0] p;
    my_x = 4'd2; my_y = 4'd3;
    do_reset();
    p = mk_pkt(9, 3);
    v_i[W] = 1'b1; data_i[W] = p;
    step();
    v_i = '0;
`ifdef MANYCORE_MESH_ROUTER_BOUNDS_DROP_EN
    n_checks++;
    if (v_o !== 5'b0) $display("FAIL bounds_drop_v: got %b want %b", v_o, 5'b0);
    else n_pass++;
    step();
    n_checks++;
    if (v_o !== 5'b0 || ready_o !== 5'b11111)
      $display("FAIL bounds_empty: got v=%b rdy=%b want v=0 rdy=11111", v_o, ready_o);
    else n_pass++;
    p = mk_pkt(2, 3);
    v_i[W] = 1'b1; data_i[W] = p;
    step();
    v_i = '0;
    n_checks++;
    if (v_o !== 5'b00001 || data_o[P] !== p)
      $display("FAIL bounds_after: got v=%b d=%h want v=00001 d=%h", v_o, data_o[P], p);
    else n_pass++;
`else
    n_checks++;
    if (v_o !== 5'b00100 || data_o[E] !== p)
      $display("FAIL bounds_route: got v=%b d=%h want v=00100 d=%h", v_o, data_o[E], p);
    else n_pass++;
`endif
    step();
  endtask

  task automatic test_random();
    logic [4:0]    exp_v;
    logic [PW-1:0] exp_d[5];
    int            gsel[5];
    int            idx;
    int            size_before[5];
    my_x = 4'($urandom_range(0, XMAX - 1));
    my_y = 4'($urandom_range(0, 15));
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mq[i].delete();
      mlast[i] = 4;
    end
    for (int c = 0; c < 600; c++) begin
      exp_v = '0;
      for (int j = 0; j < 5; j++) begin
        exp_d[j] = '0;
        gsel[j]  = -1;
        for (int off = 1; off <= 5; off++) begin
          idx = (mlast[j] + off) % 5;
          if (gsel[j] < 0 && mq[idx].size() > 0 && model_route(mq[idx][0]) == j) begin
            gsel[j]  = idx;
            exp_v[j] = 1'b1;
            exp_d[j] = mq[idx][0];
          end
        end
      end
      n_checks++;
      if (v_o !== exp_v) $display("FAIL rand_v_c%0d: got %b want %b", c, v_o, exp_v);
      else n_pass++;
      for (int j = 0; j < 5; j++) begin
        if (exp_v[j]) begin
          n_checks++;
          if (data_o[j] !== exp_d[j])
            $display("FAIL rand_d%0d_c%0d: got %h want %h", j, c, data_o[j], exp_d[j]);
          else n_pass++;
        end
      end
      for (int i = 0; i < 5; i++) begin
        size_before[i] = mq[i].size();
        n_checks++;
        if (ready_o[i] !== (size_before[i] < 2))
          $display("FAIL rand_rdy%0d_c%0d: got %b want %b", i, c, ready_o[i],
                   size_before[i] < 2);
        else n_pass++;
      end
      for (int i = 0; i < 5; i++) begin
        v_i[i]     = ($urandom_range(0, 99) < 60);
        data_i[i]  = mk_pkt($urandom_range(0, XMAX - 1), $urandom_range(0, 15));
        ready_i[i] = ($urandom_range(0, 99) < 70);
      end
      for (int j = 0; j < 5; j++) begin
        if (exp_v[j] && ready_i[j]) begin
          void'(mq[gsel[j]].pop_front());
          mlast[j] = gsel[j];
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (v_i[i] && size_before[i] < 2) mq[i].push_back(data_i[i]);
      end
      step();
    end
    v_i = '0;
    ready_i = '1;
  endtask

  initial begin
    test_reset();
    test_local();
    test_directions();
    test_contention();
    test_back_pressure();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
